// File: rtl/disagg_if.sv
// disagg_if: upstream dequeue / downstream enqueue handshake bundle for the disaggregator (receiver_last exists only with DISAGG_LAST_EN)
interface disagg_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4
);
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic sender_empty_n;
  logic sender_deq;
  logic [DATA_WIDTH-1:0] receiver_data;
  logic receiver_full_n;
  logic receiver_enq;
`ifdef DISAGG_LAST_EN
  logic receiver_last;
  modport master (output sender_data, sender_empty_n, receiver_full_n,
                  input sender_deq, receiver_data, receiver_enq, receiver_last);
  modport slave (input sender_data, sender_empty_n, receiver_full_n,
                 output sender_deq, receiver_data, receiver_enq, receiver_last);
`else
  modport master (output sender_data, sender_empty_n, receiver_full_n,
                  input sender_deq, receiver_data, receiver_enq);
  modport slave (input sender_data, sender_empty_n, receiver_full_n,
                 output sender_deq, receiver_data, receiver_enq);
`endif
endinterface

// File: rtl/disaggregator.sv
// disaggregator: splits one wide upstream word into FETCH_WIDTH narrow words, lane 0 first (optional DISAGG_LAST_EN adds receiver_last)
module disaggregator #(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  disagg_if.slave bus,
  output logic idle
);
  localparam int LW = $clog2(FETCH_WIDTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [LW-1:0] lane, lane_nx;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] hold, hold_nx;
  logic busy, last, deq, enq;
  assign busy = state == SEND;
  assign last = busy && (lane == LW'(FETCH_WIDTH - 1));
  assign enq = busy && bus.receiver_full_n;
  assign deq = bus.sender_empty_n && (!busy || (last && bus.receiver_full_n));
  assign bus.sender_deq = deq;
  assign bus.receiver_enq = enq;
  assign bus.receiver_data = hold[lane];
  assign idle = !busy;
`ifdef DISAGG_LAST_EN
  assign bus.receiver_last = last && bus.receiver_full_n;
`endif
  // state, lane pointer and held word registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lane <= '0;
      hold <= '0;
    end else begin
      state <= state_nx;
      lane <= lane_nx;
      hold <= hold_nx;
    end
  // a reload takes priority and restarts at lane 0, so the final lane and the next word overlap without a bubble
  always_comb begin
    state_nx = state;
    lane_nx = lane;
    hold_nx = hold;
    if (deq) begin
      state_nx = SEND;
      lane_nx = '0;
      hold_nx = bus.sender_data;
    end else if (enq) begin
      state_nx = last ? IDLE : SEND;
      lane_nx = last ? '0 : lane + 1'b1;
    end
  end
endmodule

// File: tb/tb_disaggregator.sv
// tb_disaggregator: directed vector table, reset cases and randomized stream check for the disaggregator
module tb_disaggregator;
  localparam int DW = 16;
  localparam int FW = 4;
  localparam logic [63:0] W0 = 64'h0003_0002_0001_0000;
  localparam logic [63:0] W1 = 64'h0007_0006_0005_0004;
  logic clk = 0;
  logic rst_n = 0;
  logic idle;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  disagg_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus();
  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .idle(idle));

  typedef struct {
    logic e, f;
    logic [63:0] d;
    logic deq, enq;
    logic [15:0] rd;
    logic idl, lst;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic last_chk(input string nm, input logic exp);
`ifdef DISAGG_LAST_EN
    chk(nm, 64'(bus.receiver_last), 64'(exp));
`else
    if (exp === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic drive(input logic e, input logic f, input logic [63:0] d);
    @(negedge clk);
    bus.sender_empty_n = e;
    bus.receiver_full_n = f;
    bus.sender_data = d;
    #1;
  endtask

  initial begin
    logic [63:0] up_q[$];
    logic [63:0] w;
    int k, emitted, loaded, pend;
    bus.sender_empty_n = 0;
    bus.receiver_full_n = 0;
    bus.sender_data = '0;
    #1;
    chk("reset_deq", 64'(bus.sender_deq), 64'd0);
    chk("reset_enq", 64'(bus.receiver_enq), 64'd0);
    chk("reset_data", 64'(bus.receiver_data), 64'd0);
    chk("reset_idle", 64'(idle), 64'd1);
    last_chk("reset_last", 1'b0);
    @(negedge clk);
    rst_n = 1;
    tbl[0]  = '{1'b1, 1'b1, W0,    1'b1, 1'b0, 16'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, W1,    1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, W1,    1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, W1,    1'b0, 1'b0, 16'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, W1,    1'b1, 1'b1, 16'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd6, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 16'd7, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 16'd4, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 16'd4, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].e, tbl[i].f, tbl[i].d);
      chk($sformatf("vec%0d_deq", i), 64'(bus.sender_deq), 64'(tbl[i].deq));
      chk($sformatf("vec%0d_enq", i), 64'(bus.receiver_enq), 64'(tbl[i].enq));
      chk($sformatf("vec%0d_data", i), 64'(bus.receiver_data), 64'(tbl[i].rd));
      chk($sformatf("vec%0d_idle", i), 64'(idle), 64'(tbl[i].idl));
      last_chk($sformatf("vec%0d_last", i), tbl[i].lst);
    end
    drive(1, 1, W0);
    chk("rmid_load", 64'(bus.sender_deq), 64'd1);
    drive(0, 1, 64'd0);
    chk("rmid_lane0", 64'(bus.receiver_data), 64'd0);
    drive(0, 1, 64'd0);
    chk("rmid_lane1", 64'(bus.receiver_data), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("rmid_enq", 64'(bus.receiver_enq), 64'd0);
    chk("rmid_idle", 64'(idle), 64'd1);
    chk("rmid_data", 64'(bus.receiver_data), 64'd0);
    @(negedge clk);
    rst_n = 1;
    drive(1, 1, W1);
    chk("rpost_deq", 64'(bus.sender_deq), 64'd1);
    chk("rpost_enq", 64'(bus.receiver_enq), 64'd0);
    drive(0, 1, 64'd0);
    chk("rpost_enq1", 64'(bus.receiver_enq), 64'd1);
    chk("rpost_data", 64'(bus.receiver_data), 64'd4);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    k = 0;
    emitted = 0;
    loaded = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      while (up_q.size() < 3) begin
        for (int j = 0; j < FW; j++) w[j*DW +: DW] = 16'(FW * k + j);
        up_q.push_back(w);
        k++;
      end
      bus.sender_empty_n = ($urandom_range(3) != 0) && (cyc < 380);
      bus.receiver_full_n = ($urandom_range(2) != 0) || (cyc >= 380);
      bus.sender_data = up_q[0];
      #1;
      pend = loaded * FW - emitted;
      chk("rnd_idle", 64'(idle), 64'(pend == 0));
      chk("rnd_enq", 64'(bus.receiver_enq), 64'(pend > 0 && bus.receiver_full_n));
      chk("rnd_deq", 64'(bus.sender_deq),
          64'(bus.sender_empty_n && (pend == 0 || (pend == 1 && bus.receiver_full_n))));
      last_chk("rnd_last", bus.receiver_enq && (emitted % FW == FW - 1));
      if (bus.receiver_enq) begin
        chk("rnd_data", 64'(bus.receiver_data), 64'(16'(emitted)));
        emitted++;
      end
      if (bus.sender_deq) begin
        void'(up_q.pop_front());
        loaded++;
      end
    end
    chk("rnd_total", 64'(emitted), 64'(loaded * FW));
    chk("rnd_progress", 64'(loaded > 40), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/disaggregator.md
Name: disaggregator

Overview:
- Width-splitting stage that serves as the inverse of the aggregator.
- Dequeues one wide word of FETCH_WIDTH*DATA_WIDTH bits from an upstream FIFO.
- Emits that word as FETCH_WIDTH narrow DATA_WIDTH words, one per cycle, into a downstream FIFO.
- Narrow order is lane 0 (LSBs) first, so aggregator -> disaggregator reproduces the original stream.

Parameters:
- DATA_WIDTH, 16, width of one narrow output word.
- FETCH_WIDTH, 4, narrow words per wide input word; legal range >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide word at the head of the upstream FIFO; lane i = bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- sender_empty_n  input  1  upstream FIFO holds a word.
- sender_deq  output  1  pops the upstream FIFO this cycle.
- receiver_data  output  DATA_WIDTH  narrow word presented downstream.
- receiver_full_n  input  1  downstream FIFO can accept a word.
- receiver_enq  output  1  pushes receiver_data downstream this cycle.
- idle  output  1  no word held, no lanes pending.

Behaviour:
- State: holding register hold[FETCH_WIDTH*DATA_WIDTH], lane counter lane[$clog2(FETCH_WIDTH)-1:0], flag busy.
- States:
  - IDLE (busy=0).
  - SEND (busy=1).
- Reset (async, rst_n=0):
  - busy=0, lane=0, hold=0.
  - Outputs: sender_deq=0, receiver_enq=0, receiver_data=0, idle=1.
- receiver_data = hold lane selected by lane (combinational mux from registers).
- receiver_enq = busy && receiver_full_n.
- last = busy && (lane == FETCH_WIDTH-1).
- sender_deq = sender_empty_n && (!busy || (last && receiver_full_n)). Never asserted while sender_empty_n=0.
- On sender_deq:
  - hold <= sender_data, lane <= 0, busy <= 1.
  - IDLE->SEND, or stays in SEND on a back-to-back reload.
- On receiver_enq without sender_deq:
  - If last: busy <= 0, lane <= 0 (SEND->IDLE).
  - Else: lane <= lane+1.
- Simultaneous final-lane enq and deq: the final lane goes out this cycle, the new word is loaded, and lane 0 of the new word is presented next cycle. No bubble.
- receiver_full_n=0 in SEND:
  - lane, hold, busy all frozen; receiver_data stable.
  - sender_deq=0, even if sender_empty_n=1.
- Latency: deq at cycle N -> lane 0 enq at earliest cycle N+1.
- Throughput: one narrow word per cycle with an unstalled downstream, i.e. one wide word per FETCH_WIDTH cycles.
- idle = !busy.
- Lane counter does not wrap past FETCH_WIDTH-1. For non-power-of-two FETCH_WIDTH, unused counter values are unreachable.
- Reset mid-word: remaining lanes discarded, nothing emitted, block returns to IDLE. The upstream word already dequeued is lost (documented behaviour).

Optional Feature:
- Macro: DISAGG_LAST_EN.
- Defined:
  - Adds output port receiver_last (1 bit) = last && receiver_full_n, i.e. high on the enq cycle of lane FETCH_WIDTH-1.
  - Reset value 0.
  - Used for downstream word-boundary tracking.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Single word: DATA_WIDTH=16, FETCH_WIDTH=4, sender_data=0x0003_0002_0001_0000, receiver_full_n=1 -> receiver_enq high 4 consecutive cycles with 0x0000, 0x0001, 0x0002, 0x0003; exactly one sender_deq; idle returns to 1.
- Back-to-back: upstream holds words 0x0003_0002_0001_0000 and 0x0007_0006_0005_0004 -> 8 consecutive enqs 0..7 with no gap; second sender_deq coincides with the enq of value 3.
- Downstream stall: receiver_full_n=0 for 3 cycles after lane 1 -> receiver_data holds 0x0001, receiver_enq=0, sender_deq=0; sequence resumes 0x0002, 0x0003.
- Random stalls: $urandom on both sender_empty_n gating and receiver_full_n over 2000 ns, counting upstream stream -> output strictly sequential 0,1,2,..., no drops or duplicates.
- Reset mid-word: assert rst_n=0 after lane 1 emitted -> receiver_enq=0, idle=1 immediately (async). After release, the next word starts at lane 0.
- DISAGG_LAST_EN defined: one word -> receiver_last high only on the cycle receiver_data=0x0003; undefined build compiles without the port.
